descrambler_sync: RTL and testbench
===================================

// Module: descrambler_sync
// PURPOSE
// - Receive-side counterpart of the 802.11a TX scrambler (x^7 + x^4 + 1, 7-bit LFSR), one bit per valid.
// - Recovers the LFSR state from the first 7 received SERVICE bits, which are scrambled zeros.
// - Then descrambles the rest of the frame.
// - Sits between the RX deinterleaver/Viterbi output and the SERVICE/PSDU parser.
// - No seed is supplied from outside.
// PARAMETERS
// - SEED_LEN  7   number of leading SERVICE bits used for state acquisition (fixed by LFSR order)
// - CNT_W     16  width of the output bit counter
// PORTS
// - clock                     in   1      single clock, rising edge
// - Descrambler_Reset         in   1      asynchronous, active-high reset
// - Descrambler_Start         in   1      sync pulse: new frame, restart seed acquisition
// - Descrambler_DataIN        in   1      received scrambled bit
// - Descrambler_DataIN_VALID  in   1      DataIN qualifier
// - Descrambler_DataOUT       out  1      descrambled bit
// - Descrambler_DataOUTVALID  out  1      DataOUT qualifier
// - Descrambler_SeedValid     out  1      high from acquisition complete until Start/reset
// - Descrambler_Seed          out  7      acquired LFSR state {r0..r6}, r0 = MSB
// - Descrambler_SeedError     out  1      acquired state is all-zero (lock-up), sticky per frame
// - Descrambler_BitCount      out  CNT_W  valid output bits since Start, saturating
// - Descrambler_ServiceError  out  1      see CONFIGURATION
// BEHAVIOUR
// - Reset (async, dominates everything). All outputs are 0 and state=IDLE.
//   - LFSR=0, counters=0.
// - FSM states: IDLE, ACQ, RUN.
//   - IDLE: input ignored, DataOUTVALID=0. Start -> ACQ.
//   - ACQ: each valid bit r does lfsr<={lfsr[5:0],r} and acq_cnt+1.
//     - Output DataOUT=0 (SERVICE[0:6] descramble to 0 by definition) with DataOUTVALID=1.
//     - On the 7th valid bit: -> RUN, SeedValid=1 next cycle, Seed=updated lfsr.
//     - SeedError=(updated lfsr==0).
//   - RUN: each valid bit: fb=lfsr[6]^lfsr[3]; DataOUT<=r^fb; lfsr<={lfsr[5:0],fb}; DataOUTVALID<=1.
//     - Stays in RUN until Start or reset.
// - Latency: DataOUT/DataOUTVALID registered, exactly 1 cycle after the DataIN_VALID cycle.
//   - DataOUTVALID=0 in any cycle following a non-valid input cycle.
// - Start in any state: acq_cnt=0, BitCount=0, SeedValid=0, SeedError=0, ServiceError=0, -> ACQ.
//   - Start and DataIN_VALID in the same cycle: that bit is seed bit r0 of the new frame.
//   - Start restarts a frame mid-acquisition or mid-RUN with no residual state.
// - Seed all-zero: RUN continues with lfsr=0, so output equals input. SeedError flags it; no stall.
// - BitCount increments on every DataOUTVALID bit, ACQ bits included. It saturates at 2^CNT_W-1 with no wrap.
// - Input bits are never dropped or back-pressured; there is no ready signal.
// CONFIGURATION
// - DESCRAMBLER_SERVICE_CHECK_EN defined:
//   - ServiceError sets 1 cycle after any descrambled SERVICE bit 7..15 (BitCount 7..15) is 1.
//   - ServiceError is sticky until Start or reset.
// - DESCRAMBLER_SERVICE_CHECK_EN undefined:
//   - the port still exists, tied to 0; no check logic is built.
// TESTING
// - Seed recovery. TX LFSR init 7'b1111111, 16 zero SERVICE bits + data.
//   - Received bits 0..6 = 0000111 -> Seed=7'b0000111.
//   - SeedValid rises the cycle after the 7th bit; DataOUT for all 16 SERVICE bits = 0.
// - Round trip. Scrambler (init 7'b1011101) feeds a 200-bit random payload after a zero SERVICE field.
//   - DataOUT equals the original stream bit-exact; BitCount=216.
// - Gapped input. DataIN_VALID toggles 1,0,0,1 randomly.
//   - Output is the same as the gapless case; DataOUTVALID mirrors input valid delayed by 1 cycle.
// - Restart mid-frame. Start asserted at bit 50 together with a valid bit.
//   - That bit becomes r0; SeedValid drops the next cycle and reasserts after 7 more bits.
//   - The new seed matches the new frame.
// - Async reset mid-RUN, asserted between clock edges.
//   - All outputs go to 0 immediately; IDLE ignores input until Start.
// - Errors. 7 received zeros -> SeedError=1 and output equals input.
//   - With DESCRAMBLER_SERVICE_CHECK_EN, SERVICE bit 9 descrambling to 1 -> ServiceError=1 until Start.

Source files
------------

// File: rtl/descrambler_sync.sv
// 802.11a receive descrambler (x^7 + x^4 + 1): recovers the LFSR state from 7 scrambled SERVICE
// zeros, then descrambles the frame. Optional SERVICE-bit check: DESCRAMBLER_SERVICE_CHECK_EN.
module descrambler_sync #(
  parameter int unsigned SEED_LEN = 7,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clock,
  input  logic             Descrambler_Reset,
  input  logic             Descrambler_Start,
  input  logic             Descrambler_DataIN,
  input  logic             Descrambler_DataIN_VALID,
  output logic             Descrambler_DataOUT,
  output logic             Descrambler_DataOUTVALID,
  output logic             Descrambler_SeedValid,
  output logic [6:0]       Descrambler_Seed,
  output logic             Descrambler_SeedError,
  output logic [CNT_W-1:0] Descrambler_BitCount,
  output logic             Descrambler_ServiceError
);

  typedef enum logic [1:0] {StIdle, StAcq, StRun} state_e;

  localparam logic [2:0] AcqLast = 3'(SEED_LEN - 1);

  state_e           state_q, state_d, proc_state;
  logic [6:0]       lfsr_q, lfsr_d, lfsr_base, seed_q, seed_d;
  logic [2:0]       acq_cnt_q, acq_cnt_d, acq_base;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d, cnt_base;
  logic             dout_q, dout_d, dvalid_q, dvalid_d;
  logic             seed_valid_q, seed_valid_d, seed_err_q, seed_err_d;
  logic             fb, acq_done, svc_err;

  always_ff @(posedge clock or posedge Descrambler_Reset) begin
    if (Descrambler_Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (Descrambler_Start) begin
      state_d = StAcq;
    end else if (acq_done) begin
      state_d = StRun;
    end
  end

  // Start wipes the frame context so a bit arriving with it is processed as seed bit r0.
  always_comb begin
    proc_state   = Descrambler_Start ? StAcq : state_q;
    lfsr_base    = Descrambler_Start ? 7'd0 : lfsr_q;
    acq_base     = Descrambler_Start ? 3'd0 : acq_cnt_q;
    cnt_base     = Descrambler_Start ? '0 : bit_cnt_q;
    fb           = lfsr_base[6] ^ lfsr_base[3];
    lfsr_d       = lfsr_base;
    acq_cnt_d    = acq_base;
    bit_cnt_d    = cnt_base;
    seed_d       = Descrambler_Start ? 7'd0 : seed_q;
    seed_valid_d = Descrambler_Start ? 1'b0 : seed_valid_q;
    seed_err_d   = Descrambler_Start ? 1'b0 : seed_err_q;
    dout_d       = 1'b0;
    dvalid_d     = 1'b0;
    acq_done     = 1'b0;
    if (Descrambler_DataIN_VALID && proc_state != StIdle) begin
      dvalid_d = 1'b1;
      if (cnt_base != '1) begin
        bit_cnt_d = cnt_base + CNT_W'(1);
      end
      if (proc_state == StAcq) begin
        lfsr_d    = {lfsr_base[5:0], Descrambler_DataIN};
        acq_cnt_d = acq_base + 3'd1;
        if (acq_base == AcqLast) begin
          acq_done     = 1'b1;
          seed_valid_d = 1'b1;
          seed_d       = lfsr_d;
          seed_err_d   = (lfsr_d == 7'd0);
        end
      end else begin
        dout_d = Descrambler_DataIN ^ fb;
        lfsr_d = {lfsr_base[5:0], fb};
      end
    end
  end

  always_ff @(posedge clock or posedge Descrambler_Reset) begin
    if (Descrambler_Reset) begin
      lfsr_q       <= '0;
      seed_q       <= '0;
      acq_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      dout_q       <= 1'b0;
      dvalid_q     <= 1'b0;
      seed_valid_q <= 1'b0;
      seed_err_q   <= 1'b0;
    end else begin
      lfsr_q       <= lfsr_d;
      seed_q       <= seed_d;
      acq_cnt_q    <= acq_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      dout_q       <= dout_d;
      dvalid_q     <= dvalid_d;
      seed_valid_q <= seed_valid_d;
      seed_err_q   <= seed_err_d;
    end
  end

`ifdef DESCRAMBLER_SERVICE_CHECK_EN
  logic svc_err_q, svc_err_d;

  // SERVICE bits 7..15 are reserved and must descramble to 0.
  always_comb begin
    svc_err_d = Descrambler_Start ? 1'b0 : svc_err_q;
    if (Descrambler_DataIN_VALID && proc_state == StRun && dout_d &&
        cnt_base >= CNT_W'(SEED_LEN) && cnt_base <= CNT_W'(15)) begin
      svc_err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge Descrambler_Reset) begin
    if (Descrambler_Reset) begin
      svc_err_q <= 1'b0;
    end else begin
      svc_err_q <= svc_err_d;
    end
  end

  assign svc_err = svc_err_q;
`else
  assign svc_err = 1'b0;
`endif

  always_comb begin
    Descrambler_DataOUT      = dout_q;
    Descrambler_DataOUTVALID = dvalid_q;
    Descrambler_SeedValid    = seed_valid_q;
    Descrambler_Seed         = seed_q;
    Descrambler_SeedError    = seed_err_q;
    Descrambler_BitCount     = bit_cnt_q;
    Descrambler_ServiceError = svc_err;
  end

endmodule

// File: tb/tb_descrambler_sync.sv
// Self-checking bench for descrambler_sync: a reference 802.11a scrambler feeds the DUT and a
// scoreboard queue holds the original (pre-scrambling) bits expected on DataOUT.
module tb_descrambler_sync;

  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             Descrambler_Reset;
  logic             Descrambler_Start;
  logic             Descrambler_DataIN;
  logic             Descrambler_DataIN_VALID;
  logic             Descrambler_DataOUT;
  logic             Descrambler_DataOUTVALID;
  logic             Descrambler_SeedValid;
  logic [6:0]       Descrambler_Seed;
  logic             Descrambler_SeedError;
  logic [CNT_W-1:0] Descrambler_BitCount;
  logic             Descrambler_ServiceError;

  int         checks = 0;
  int         errors = 0;
  bit         exp_q[$];
  bit         active = 1'b0;
  logic [6:0] tx_q;
  logic [6:0] seed_exp;
  bit         payload[200];
  bit         svc_on;

  descrambler_sync #(.SEED_LEN(7), .CNT_W(CNT_W)) dut (
    .clock                    (clock),
    .Descrambler_Reset        (Descrambler_Reset),
    .Descrambler_Start        (Descrambler_Start),
    .Descrambler_DataIN       (Descrambler_DataIN),
    .Descrambler_DataIN_VALID (Descrambler_DataIN_VALID),
    .Descrambler_DataOUT      (Descrambler_DataOUT),
    .Descrambler_DataOUTVALID (Descrambler_DataOUTVALID),
    .Descrambler_SeedValid    (Descrambler_SeedValid),
    .Descrambler_Seed         (Descrambler_Seed),
    .Descrambler_SeedError    (Descrambler_SeedError),
    .Descrambler_BitCount     (Descrambler_BitCount),
    .Descrambler_ServiceError (Descrambler_ServiceError)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, then check valid and (via the scoreboard) the data that edge produced.
  task automatic send(input bit s, input bit v, input bit d, input bit e);
    bit exp_v;
    bit got;
    Descrambler_Start        = s;
    Descrambler_DataIN_VALID = v;
    Descrambler_DataIN       = d;
    if (s) active = 1'b1;
    exp_v = v && active;
    if (exp_v) exp_q.push_back(e);
    @(posedge clock);
    #1;
    chk("out_valid", {31'd0, Descrambler_DataOUTVALID}, {31'd0, exp_v});
    if (exp_v && exp_q.size() > 0) begin
      got = exp_q.pop_front();
      chk("dout", {31'd0, Descrambler_DataOUT}, {31'd0, got});
    end
    Descrambler_Start        = 1'b0;
    Descrambler_DataIN_VALID = 1'b0;
  endtask

  // Reference transmit scrambler: scrambles one original bit and sends it.
  task automatic tx_send(input bit s, input bit orig);
    bit f;
    f    = tx_q[6] ^ tx_q[3];
    tx_q = {tx_q[5:0], f};
    send(s, 1'b1, orig ^ f, orig);
  endtask

  task automatic gap();
    if ($urandom_range(0, 1) == 1) begin
      repeat ($urandom_range(1, 2)) send(1'b0, 1'b0, 1'($urandom), 1'b0);
    end
  endtask

  initial begin
    Descrambler_Reset        = 1'b1;
    Descrambler_Start        = 1'b0;
    Descrambler_DataIN       = 1'b0;
    Descrambler_DataIN_VALID = 1'b0;
    for (int i = 0; i < 200; i++) payload[i] = 1'($urandom);
    #12;
    chk("rst_valid", {31'd0, Descrambler_DataOUTVALID}, 32'd0);
    chk("rst_count", {16'd0, Descrambler_BitCount}, 32'd0);
    chk("rst_seed", {25'd0, Descrambler_Seed}, 32'd0);
    chk("rst_seedvalid", {31'd0, Descrambler_SeedValid}, 32'd0);
    @(negedge clock);
    Descrambler_Reset = 1'b0;

    // Idle ignores input until Start.
    send(1'b0, 1'b1, 1'b1, 1'b0);
    send(1'b0, 1'b1, 1'b0, 1'b0);
    chk("idle_count", {16'd0, Descrambler_BitCount}, 32'd0);

    // Seed recovery from an all-ones transmitter state.
    tx_q = 7'h7F;
    for (int i = 0; i < 16; i++) begin
      tx_send(i == 0, 1'b0);
      if (i == 5) chk("seedvalid_early", {31'd0, Descrambler_SeedValid}, 32'd0);
      if (i == 6) begin
        chk("seedvalid", {31'd0, Descrambler_SeedValid}, 32'd1);
        chk("seed_ones", {25'd0, Descrambler_Seed}, 32'h07);
        chk("seederr_ones", {31'd0, Descrambler_SeedError}, 32'd0);
      end
    end
    for (int i = 0; i < 20; i++) tx_send(1'b0, payload[i]);
    chk("count_seedtest", {16'd0, Descrambler_BitCount}, 32'd36);
    chk("svcerr_clean", {31'd0, Descrambler_ServiceError}, 32'd0);

    // Round trip, gapless.
    tx_q = 7'b1011101;
    for (int i = 0; i < 16; i++) begin
      tx_send(i == 0, 1'b0);
      if (i == 6) seed_exp = tx_q;
    end
    for (int i = 0; i < 200; i++) tx_send(1'b0, payload[i]);
    chk("count_rt", {16'd0, Descrambler_BitCount}, 32'd216);
    chk("seed_rt", {25'd0, Descrambler_Seed}, {25'd0, seed_exp});

    // Round trip with random valid gaps.
    tx_q = 7'b1011101;
    for (int i = 0; i < 16; i++) begin
      if (i != 0) gap();
      tx_send(i == 0, 1'b0);
    end
    for (int i = 0; i < 200; i++) begin
      gap();
      tx_send(1'b0, payload[i]);
    end
    chk("count_gap", {16'd0, Descrambler_BitCount}, 32'd216);

    // Restart at bit 50 of a frame, Start coincident with the first bit of the new frame.
    tx_q = 7'h55;
    for (int i = 0; i < 16; i++) tx_send(i == 0, 1'b0);
    for (int i = 0; i < 34; i++) tx_send(1'b0, payload[i]);
    tx_q = 7'b0110011;
    tx_send(1'b1, 1'b0);
    chk("restart_seedvalid", {31'd0, Descrambler_SeedValid}, 32'd0);
    chk("restart_count", {16'd0, Descrambler_BitCount}, 32'd1);
    for (int i = 1; i < 16; i++) begin
      tx_send(1'b0, 1'b0);
      if (i == 5) chk("restart_sv_early", {31'd0, Descrambler_SeedValid}, 32'd0);
      if (i == 6) begin
        chk("restart_sv", {31'd0, Descrambler_SeedValid}, 32'd1);
        chk("restart_seed", {25'd0, Descrambler_Seed}, {25'd0, tx_q});
      end
    end
    for (int i = 0; i < 30; i++) tx_send(1'b0, payload[100 + i]);
    chk("restart_count_end", {16'd0, Descrambler_BitCount}, 32'd46);

    // Asynchronous reset between edges while in RUN.
    #2;
    Descrambler_Reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, Descrambler_DataOUTVALID}, 32'd0);
    chk("arst_count", {16'd0, Descrambler_BitCount}, 32'd0);
    chk("arst_seedvalid", {31'd0, Descrambler_SeedValid}, 32'd0);
    chk("arst_seed", {25'd0, Descrambler_Seed}, 32'd0);
    active = 1'b0;
    @(negedge clock);
    Descrambler_Reset = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b0, 1'b1, 1'b1, 1'b0);
    chk("arst_idle_count", {16'd0, Descrambler_BitCount}, 32'd0);

    // All-zero seed: lock-up flagged, output equals input.
    for (int i = 0; i < 7; i++) send(i == 0, 1'b1, 1'b0, 1'b0);
    chk("zero_seederr", {31'd0, Descrambler_SeedError}, 32'd1);
    chk("zero_seedvalid", {31'd0, Descrambler_SeedValid}, 32'd1);
    for (int i = 0; i < 20; i++) send(1'b0, 1'b1, payload[50 + i], payload[50 + i]);
    chk("zero_seederr_held", {31'd0, Descrambler_SeedError}, 32'd1);
    chk("zero_count", {16'd0, Descrambler_BitCount}, 32'd27);
    send(1'b1, 1'b0, 1'b0, 1'b0);
    chk("start_clears_seederr", {31'd0, Descrambler_SeedError}, 32'd0);

    // SERVICE bit 9 set: flagged only when the check is built.
`ifdef DESCRAMBLER_SERVICE_CHECK_EN
    svc_on = 1'b1;
`else
    svc_on = 1'b0;
`endif
    tx_q = 7'h7F;
    for (int i = 0; i < 16; i++) begin
      tx_send(i == 0, i == 9);
      if (i == 8) chk("svc_before", {31'd0, Descrambler_ServiceError}, 32'd0);
      if (i == 9) chk("svc_set", {31'd0, Descrambler_ServiceError}, {31'd0, svc_on});
    end
    for (int i = 0; i < 10; i++) tx_send(1'b0, payload[i]);
    chk("svc_sticky", {31'd0, Descrambler_ServiceError}, {31'd0, svc_on});
    send(1'b1, 1'b0, 1'b0, 1'b0);
    chk("svc_cleared", {31'd0, Descrambler_ServiceError}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
